bw_icache_fill_ctrl: RTL
========================

BW_ICACHE_FILL_CTRL -- requirements
Module: bw_icache_fill_ctrl

Interface
REQ-001 SHALL have parameters: AWID, default 32, address width; WAYS, default 4, cache ways; LINES, default 128, lines per way; BEATS, default 4, memory beats per 64-byte line; DWID, default 128, beat data width.
REQ-002 SHALL have ports (name, direction, width, meaning):
- rst  in  1  reset; asynchronous, active-high
- clk  in  1  single clock
- miss  in  1  fetch miss request (level)
- miss_ip  in  AWID  missing fetch address
- miss_done  out  1  one-cycle pulse when the line is committed
- miss_err  out  1  one-cycle pulse when a fill is aborted
- inv_req  in  1  invalidate request (level)
- inv_all  in  1  with inv_req: invalidate all lines
- inv_adr  in  AWID  physical address for a line invalidate
- inv_ack  out  1  one-cycle pulse when the invalidate is issued
- mem_req  out  1  memory burst request
- mem_adr  out  AWID  burst address, line-aligned (bits [5:0] zero)
- mem_ack  in  1  burst accepted
- mem_vld  in  1  beat valid
- mem_dat  in  DWID  beat data
- mem_err  in  1  bus error, sampled with mem_vld
- dat_we  out  1  cache data RAM write strobe
- dat_way  out  2  data RAM way
- dat_beat  out  2  beat index within the line
- dat_o  out  DWID  data RAM write data
- v_wr, v_way[1:0], v_ip[AWID-1:0]  out  valid-array set-line controls
- v_invce, v_invline, v_invall, v_adr[AWID-1:0]  out  valid-array invalidate controls
- busy  out  1  state is not IDLE

Function
REQ-003 SHALL implement the states IDLE, REQ, FILL, COMMIT, INV, ERR.
REQ-004 IDLE: if inv_req, go to INV; else if miss, latch miss_ip and the victim way, then go to REQ. A pending invalidate always wins over a miss.
REQ-005 REQ: hold mem_req=1 and mem_adr={miss_ip[AWID-1:6],6'b0}; on mem_ack, drop mem_req on the next cycle, clear the beat counter, go to FILL.
REQ-006 FILL: each cycle with mem_vld=1 and mem_err=0 SHALL assert dat_we the same cycle, with dat_beat=counter, dat_o=mem_dat, dat_way=latched way, then increment the counter.
- When the beat with index BEATS-1 is accepted, go to COMMIT.
- mem_err=1 with mem_vld=1 goes to ERR; no dat_we that cycle.
REQ-007 COMMIT: v_wr=1 for exactly one cycle, with v_way=latched way and v_ip=latched ip; miss_done pulses the same cycle; advance the victim pointer; return to IDLE.
REQ-008 ERR: miss_err pulses for one cycle; no v_wr; victim pointer unchanged; return to IDLE.
REQ-009 INV: v_invce=1 for one cycle, with v_invall=inv_all, v_invline=~inv_all, v_adr=inv_adr; inv_ack pulses the same cycle; return to IDLE.
REQ-010 inv_req arriving during REQ/FILL SHALL be held off until the fill completes or aborts; the fill SHALL NOT be cancelled.
- If the pending invalidate is a line invalidate whose inv_adr[12:6] equals the committed line, it SHALL still be issued in the INV state after COMMIT; the line ends invalid.
REQ-011 v_wr and v_invce SHALL never be asserted in the same cycle. At most one dat_we per cycle.
REQ-012 Victim way: a 2-bit round-robin pointer, incremented modulo WAYS on each COMMIT, wrapping from 3 to 0.
REQ-013 mem_vld outside FILL SHALL be ignored. Latency from miss (in IDLE) to mem_req is 1 cycle; from the last beat to v_wr is 1 cycle.

Reset
REQ-014 Asynchronous assertion of rst SHALL force state=IDLE, victim pointer=0, beat counter=0, and all outputs to 0, including mid-fill. No v_wr or dat_we is issued after reset.

Structure
REQ-015 The state enumeration and the line-offset constant (6) SHALL reside in rfBlackWidowPkg.
REQ-016 The round-robin victim pointer SHALL be a sub-module named bw_icache_victim_rr, with inputs clk, rst and adv, and output way[1:0].

Verification
REQ-017 Miss at ip 0x0000_1234, mem_ack after 2 cycles, 4 clean beats:
- mem_adr=0x0000_1200
- dat_beat 0..3 on way 0
- one-cycle v_wr with v_way=0 and v_ip=0x1234
- miss_done pulse
REQ-018 Four back-to-back misses: v_way sequence 0,1,2,3; a fifth miss uses way 0.
REQ-019 mem_err on beat 2:
- dat_we only for beats 0 and 1
- miss_err pulse, no v_wr
- the next miss reuses the same way
REQ-020 inv_req with inv_all=0 and inv_adr=0x1240 asserted during FILL of line 0x1200:
- v_wr first
- next cycle v_invce=1, v_invline=1, v_adr=0x1240
- inv_ack pulse
REQ-021 miss and inv_req with inv_all=1 in the same IDLE cycle: INV first (v_invall=1), then mem_req on the following cycles.
REQ-022 rst asserted during FILL beat 1: all outputs 0 immediately, state IDLE; the subsequent miss starts a fresh burst on way 0.

Source files
------------

// File: rtl/bw_icache_fill_ctrl_pkg.sv
// Shared types and constants for the instruction-cache line fill controller.
package rfBlackWidowPkg;

    localparam int LINE_OFS = 6;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_FILL,
        ST_COMMIT,
        ST_INV,
        ST_ERR
    } fill_state_e;

endpackage

// File: rtl/bw_icache_victim_rr.sv
// Round-robin victim way selector; steps once per committed line fill.
module bw_icache_victim_rr #(
    parameter int WAYS = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       adv,
    output logic [1:0] way
);

    logic [1:0] way_q, way_d;

    always_comb begin
        way_d = way_q;
        if (adv) begin
            way_d = (way_q == 2'(WAYS - 1)) ? 2'd0 : way_q + 2'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) way_q <= 2'd0;
        else     way_q <= way_d;
    end

    assign way = way_q;

endmodule

// File: rtl/bw_icache_fill_ctrl.sv
// I-cache miss fill controller: bursts a line from memory into the data RAM,
// sets the valid bit on completion and serialises invalidates with fills.
module bw_icache_fill_ctrl
    import rfBlackWidowPkg::*;
#(
    parameter int AWID  = 32,
    parameter int WAYS  = 4,
    parameter int LINES = 128,
    parameter int BEATS = 4,
    parameter int DWID  = 128
) (
    input  logic            rst,
    input  logic            clk,
    input  logic            miss,
    input  logic [AWID-1:0] miss_ip,
    output logic            miss_done,
    output logic            miss_err,
    input  logic            inv_req,
    input  logic            inv_all,
    input  logic [AWID-1:0] inv_adr,
    output logic            inv_ack,
    output logic            mem_req,
    output logic [AWID-1:0] mem_adr,
    input  logic            mem_ack,
    input  logic            mem_vld,
    input  logic [DWID-1:0] mem_dat,
    input  logic            mem_err,
    output logic            dat_we,
    output logic [1:0]      dat_way,
    output logic [1:0]      dat_beat,
    output logic [DWID-1:0] dat_o,
    output logic            v_wr,
    output logic [1:0]      v_way,
    output logic [AWID-1:0] v_ip,
    output logic            v_invce,
    output logic            v_invline,
    output logic            v_invall,
    output logic [AWID-1:0] v_adr,
    output logic            busy
);

    localparam int         IDX_W     = $clog2(LINES);
    localparam logic [1:0] LAST_BEAT = 2'(BEATS - 1);

    fill_state_e     state_q, state_d;
    logic [AWID-1:0] ip_q, ip_d;
    logic [1:0]      way_q, way_d;
    logic [1:0]      cnt_q, cnt_d;
    logic [1:0]      victim;
    logic            adv;

    // Set index of the line in flight; kept for debug visibility only.
    logic [IDX_W-1:0] unused_set;
    assign unused_set = ip_q[LINE_OFS +: IDX_W];

    bw_icache_victim_rr #(.WAYS(WAYS)) u_victim (
        .clk (clk),
        .rst (rst),
        .adv (adv),
        .way (victim)
    );

    always_comb begin
        state_d   = state_q;
        ip_d      = ip_q;
        way_d     = way_q;
        cnt_d     = cnt_q;
        adv       = 1'b0;
        miss_done = 1'b0;
        miss_err  = 1'b0;
        inv_ack   = 1'b0;
        mem_req   = 1'b0;
        mem_adr   = '0;
        dat_we    = 1'b0;
        dat_way   = 2'd0;
        dat_beat  = 2'd0;
        dat_o     = '0;
        v_wr      = 1'b0;
        v_way     = 2'd0;
        v_ip      = '0;
        v_invce   = 1'b0;
        v_invline = 1'b0;
        v_invall  = 1'b0;
        v_adr     = '0;

        case (state_q)
            ST_IDLE: begin
                if (inv_req) begin
                    state_d = ST_INV;
                end else if (miss) begin
                    ip_d    = miss_ip;
                    way_d   = victim;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                mem_req = 1'b1;
                mem_adr = {ip_q[AWID-1:LINE_OFS], {LINE_OFS{1'b0}}};
                if (mem_ack) begin
                    cnt_d   = 2'd0;
                    state_d = ST_FILL;
                end
            end
            ST_FILL: begin
                if (mem_vld && mem_err) begin
                    state_d = ST_ERR;
                end else if (mem_vld) begin
                    dat_we   = 1'b1;
                    dat_way  = way_q;
                    dat_beat = cnt_q;
                    dat_o    = mem_dat;
                    cnt_d    = cnt_q + 2'd1;
                    if (cnt_q == LAST_BEAT) state_d = ST_COMMIT;
                end
            end
            ST_COMMIT: begin
                v_wr      = 1'b1;
                v_way     = way_q;
                v_ip      = ip_q;
                miss_done = 1'b1;
                adv       = 1'b1;
                // An invalidate held off during the fill issues right after,
                // so a same-line invalidate leaves the line invalid.
                state_d   = inv_req ? ST_INV : ST_IDLE;
            end
            ST_ERR: begin
                miss_err = 1'b1;
                state_d  = inv_req ? ST_INV : ST_IDLE;
            end
            ST_INV: begin
                v_invce   = 1'b1;
                v_invall  = inv_all;
                v_invline = ~inv_all;
                v_adr     = inv_adr;
                inv_ack   = 1'b1;
                state_d   = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign busy = (state_q != ST_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ip_q    <= '0;
            way_q   <= 2'd0;
            cnt_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            ip_q    <= ip_d;
            way_q   <= way_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule
